screen_sweep_datapath: RTL and testbench
========================================

SCREEN_SWEEP_DATAPATH -- requirements
Module: screen_sweep_datapath

Interface
REQ-001 The parameter WIDTH SHALL default to 160 and set the number of pixel columns, x in 0..WIDTH-1.
REQ-002 The parameter HEIGHT SHALL default to 120 and set the number of pixel rows, y in 0..HEIGHT-1.
REQ-003 The ports SHALL be:
- clock  in  1  single clock; all state changes on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- initx  in  1  load value for x is 0 (from the control FSM).
- inity  in  1  load value for y is 0.
- loadx  in  1  update the x counter this cycle.
- loady  in  1  update the y counter this cycle.
- plot  in  1  FSM request to write the current pixel.
- colour_mode  in  1  selects the colour source: 0 = fill_colour, 1 = pattern.
- fill_colour  in  3  solid fill colour.
- xdone  out  1  column sweep complete.
- ydone  out  1  row sweep of the current column complete.
- vga_x  out  8  pixel x sent to the VGA adapter.
- vga_y  out  7  pixel y sent to the VGA adapter.
- vga_colour  out  3  pixel colour sent to the VGA adapter.
- vga_plot  out  1  pixel write strobe to the VGA adapter.
- pixel_count  out  15  number of pixels plotted since the last sweep start.
- frame_done  out  1  sticky flag: a full sweep has finished.

Function
REQ-004 The x counter (8 bits) SHALL update on a rising edge only when loadx=1:
- initx=1 → 0
- initx=0 → x+1
REQ-005 The y counter (7 bits) SHALL update on a rising edge only when loady=1:
- inity=1 → 0
- inity=0 → y+1
REQ-006 When its load input is 0, a counter SHALL hold its value; x and y SHALL be independent, so simultaneous loads both take effect in the same cycle.
REQ-007 ydone SHALL be combinational and equal to 1 exactly when y == HEIGHT, the value one past the last row.
REQ-008 xdone SHALL be combinational and equal to 1 exactly when x == WIDTH, the value one past the last column.
REQ-009 Counters SHALL NOT saturate or clamp; increments beyond WIDTH or HEIGHT wrap modulo 2^8 or 2^7, and the upstream FSM is responsible for preventing this.
REQ-010 A pixel is valid when plot=1 and xdone=0 and ydone=0.
REQ-011 The output stage SHALL be one register deep: on each rising edge it SHALL capture vga_x<=x, vga_y<=y, vga_colour<=colour and vga_plot<=pixel_valid, giving exactly one cycle of latency from counter value to VGA outputs.
REQ-012 colour SHALL be fill_colour when colour_mode=0, and x[2:0] XOR y[2:0] when colour_mode=1; colour_mode and fill_colour are sampled on the same edge as x and y.
REQ-013 pixel_count SHALL increment by 1 on each edge where pixel_valid=1, and SHALL saturate at 32767.
REQ-014 A sweep start is defined as loadx=1, loady=1, initx=1 and inity=1 on the same edge; it SHALL clear pixel_count to 0 and frame_done to 0.
REQ-015 A sweep start SHALL take priority over a simultaneous increment of pixel_count.
REQ-016 frame_done SHALL be set on the first edge where xdone=1, and SHALL stay set until the next sweep start or reset.
REQ-017 When plot=1 while xdone or ydone is 1, the request SHALL be suppressed: vga_plot=0 on the next cycle and pixel_count unchanged.
REQ-018 With WIDTH=160 and HEIGHT=120, one full sweep driven by the clear FSM SHALL produce exactly 19200 vga_plot pulses, in column-major order: y inner loop, x outer loop.

Reset
REQ-019 While resetb=0, independent of clock, all of the following SHALL be 0: x, y, vga_x, vga_y, vga_colour, vga_plot, pixel_count and frame_done.
REQ-020 On reset release, xdone and ydone SHALL be 0 (x=0, y=0); the first state change SHALL occur on the first rising edge with resetb=1.
REQ-021 Reset asserted mid-sweep SHALL abort the sweep immediately: vga_plot drops to 0 without waiting for a clock edge, and no partial state survives.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Sweep start, then plot=1 with loady=1 for 3 cycles → vga_y sequence 0,1,2, each one cycle after y, vga_plot=1 each cycle, pixel_count=3.
- y reaches 120 → ydone=1 and no plot on the next cycle; loadx=1, loady=1, inity=1 → x=1, y=0, ydone=0.
- Full sweep with the clear FSM, WIDTH=160, HEIGHT=120 → 19200 vga_plot pulses, last pixel (159,119), xdone=1 with x=160, frame_done=1, pixel_count=19200.
- colour_mode=1 at x=5, y=3 → vga_colour=3'b110; colour_mode=0 with fill_colour=3'b010 → vga_colour=3'b010.
- resetb=0 mid-sweep at x=80, y=60 → all outputs 0 asynchronously; after release, a sweep start restarts at (0,0) with pixel_count=0.
- Sweep start issued after frame_done=1 → frame_done=0 and pixel_count=0 on that edge, even if plot=1 on the same edge.

Source files
------------

// File: rtl/screen_sweep_datapath.sv
// Screen-clear datapath: x/y sweep counters, pixel colour select and a one-register VGA output stage (1 cycle latency).
// No backpressure: plot requests while xdone/ydone is high are dropped, and pixel_count saturates instead of wrapping.
module screen_sweep_datapath #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        initx,
    input  logic        inity,
    input  logic        loadx,
    input  logic        loady,
    input  logic        plot,
    input  logic        colour_mode,
    input  logic [2:0]  fill_colour,
    output logic        xdone,
    output logic        ydone,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [14:0] pixel_count,
    output logic        frame_done
);

    localparam logic [7:0]  X_END   = 8'(WIDTH);
    localparam logic [6:0]  Y_END   = 7'(HEIGHT);
    localparam logic [14:0] CNT_MAX = 15'h7FFF;

    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [7:0]  r_vga_x;
    logic [6:0]  r_vga_y;
    logic [2:0]  r_vga_colour;
    logic        r_vga_plot;
    logic [14:0] r_pixel_count;
    logic        r_frame_done;

    logic        w_xdone;
    logic        w_ydone;
    logic        w_pixel_valid;
    logic        w_sweep_start;
    logic [2:0]  w_colour;

    assign w_xdone       = (r_x == X_END);
    assign w_ydone       = (r_y == Y_END);
    assign w_pixel_valid = plot & ~w_xdone & ~w_ydone;
    assign w_sweep_start = loadx & loady & initx & inity;
    assign w_colour      = colour_mode ? (r_x[2:0] ^ r_y[2:0]) : fill_colour;

    // Counters wrap freely; the controlling FSM stops at the one-past-last values.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (loadx) r_x <= initx ? 8'd0 : r_x + 8'd1;
            if (loady) r_y <= inity ? 7'd0 : r_y + 7'd1;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_vga_x      <= r_x;
            r_vga_y      <= r_y;
            r_vga_colour <= w_colour;
            r_vga_plot   <= w_pixel_valid;
        end
    end

    // A sweep start clears the statistics even if a pixel is plotted on the same edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_pixel_count <= '0;
            r_frame_done  <= 1'b0;
        end else if (w_sweep_start) begin
            r_pixel_count <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_pixel_valid && r_pixel_count != CNT_MAX)
                r_pixel_count <= r_pixel_count + 15'd1;
            if (w_xdone)
                r_frame_done <= 1'b1;
        end
    end

    assign xdone       = w_xdone;
    assign ydone       = w_ydone;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;
    assign pixel_count = r_pixel_count;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_screen_sweep_datapath.sv
// Directed bench for screen_sweep_datapath: vector table plus multi-cycle sequences.
module tb_screen_sweep_datapath;

    logic        clock = 1'b0;
    logic        resetb;
    logic        initx, inity, loadx, loady, plot, colour_mode;
    logic [2:0]  fill_colour;
    logic        xdone, ydone;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [14:0] pixel_count;
    logic        frame_done;

    int n_chk  = 0;
    int n_fail = 0;

    screen_sweep_datapath #(.WIDTH(160), .HEIGHT(120)) dut (
        .clock       (clock),
        .resetb      (resetb),
        .initx       (initx),
        .inity       (inity),
        .loadx       (loadx),
        .loady       (loady),
        .plot        (plot),
        .colour_mode (colour_mode),
        .fill_colour (fill_colour),
        .xdone       (xdone),
        .ydone       (ydone),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .pixel_count (pixel_count),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ix, iy, lx, ly, pl, cm;
        logic [2:0]  fill;
        logic [7:0]  ex;
        logic [6:0]  ey;
        logic [2:0]  ec;
        logic        ep;
        logic [14:0] ecnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ix, input logic iy, input logic lx, input logic ly,
                         input logic pl, input logic cm, input logic [2:0] fc);
        initx = ix; inity = iy; loadx = lx; loady = ly;
        plot = pl; colour_mode = cm; fill_colour = fc;
    endtask

    int pulses, cycles, order_errs, ex, ey;
    logic [7:0] last_x;
    logic [6:0] last_y;

    initial begin
        //               ix iy lx ly pl cm fill    ex ey ec     ep cnt
        vecs[0]  = '{1, 1, 1, 1, 0, 0, 3'b010, 0, 0, 3'b010, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 1, 0, 3'b010, 0, 0, 3'b010, 1, 1};
        vecs[2]  = '{0, 0, 0, 1, 1, 0, 3'b010, 0, 1, 3'b010, 1, 2};
        vecs[3]  = '{0, 0, 0, 1, 1, 0, 3'b010, 0, 2, 3'b010, 1, 3};
        vecs[4]  = '{0, 0, 0, 0, 0, 1, 3'b000, 0, 3, 3'b011, 0, 3};
        vecs[5]  = '{0, 0, 1, 0, 0, 1, 3'b000, 0, 3, 3'b011, 0, 3};
        vecs[6]  = '{0, 0, 1, 0, 0, 1, 3'b000, 1, 3, 3'b010, 0, 3};
        vecs[7]  = '{0, 0, 1, 0, 0, 1, 3'b000, 2, 3, 3'b001, 0, 3};
        vecs[8]  = '{0, 0, 1, 0, 0, 1, 3'b000, 3, 3, 3'b000, 0, 3};
        vecs[9]  = '{0, 0, 1, 0, 0, 1, 3'b000, 4, 3, 3'b111, 0, 3};
        vecs[10] = '{0, 0, 0, 0, 1, 1, 3'b000, 5, 3, 3'b110, 1, 4};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 3'b010, 5, 3, 3'b010, 1, 5};

        resetb = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 3'b000);
        #12;
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_vga_colour", vga_colour, 0);
        chk("rst_vga_plot", vga_plot, 0);
        chk("rst_pixel_count", pixel_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_xdone", xdone, 0);
        chk("rst_ydone", ydone, 0);
        @(negedge clock);
        resetb = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ix, vecs[i].iy, vecs[i].lx, vecs[i].ly, vecs[i].pl, vecs[i].cm, vecs[i].fill);
            step();
            chk($sformatf("v%0d_vga_x", i), vga_x, vecs[i].ex);
            chk($sformatf("v%0d_vga_y", i), vga_y, vecs[i].ey);
            chk($sformatf("v%0d_vga_colour", i), vga_colour, vecs[i].ec);
            chk($sformatf("v%0d_vga_plot", i), vga_plot, vecs[i].ep);
            chk($sformatf("v%0d_pixel_count", i), pixel_count, vecs[i].ecnt);
        end

        // y from 3 up to one past the last row, then a suppressed plot
        drive(0, 0, 0, 1, 0, 0, 3'b001);
        for (int i = 0; i < 117; i++) step();
        chk("y_end_ydone", ydone, 1);
        chk("y_end_xdone", xdone, 0);
        drive(0, 0, 0, 0, 1, 0, 3'b001);
        step();
        chk("y_end_suppress_plot", vga_plot, 0);
        chk("y_end_vga_y", vga_y, 120);
        chk("y_end_count_held", pixel_count, 5);
        drive(0, 1, 1, 1, 0, 0, 3'b001);
        step();
        chk("col_adv_ydone", ydone, 0);
        drive(0, 0, 0, 0, 1, 0, 3'b001);
        step();
        chk("col_adv_vga_x", vga_x, 6);
        chk("col_adv_vga_y", vga_y, 0);
        chk("col_adv_plot", vga_plot, 1);
        chk("col_adv_count", pixel_count, 6);

        // Full sweep driven by a bench-side clear FSM
        drive(1, 1, 1, 1, 0, 0, 3'b100);
        step();
        chk("sweep_start_count", pixel_count, 0);
        pulses = 0; cycles = 0; order_errs = 0; ex = 0; ey = 0;
        last_x = '0; last_y = '0;
        while (!xdone && cycles < 25000) begin
            if (!ydone) drive(0, 0, 0, 1, 1, 0, 3'b100);
            else        drive(0, 1, 1, 1, 0, 0, 3'b100);
            step();
            cycles++;
            if (vga_plot) begin
                pulses++;
                if (vga_x != 8'(ex) || vga_y != 7'(ey)) order_errs++;
                last_x = vga_x; last_y = vga_y;
                if (ey == 119) begin ey = 0; ex++; end
                else ey++;
            end
        end
        chk("sweep_reached_xdone", xdone, 1);
        chk("sweep_pulses", pulses, 19200);
        chk("sweep_order_errors", order_errs, 0);
        chk("sweep_last_x", last_x, 159);
        chk("sweep_last_y", last_y, 119);
        chk("sweep_count", pixel_count, 19200);
        drive(0, 0, 0, 0, 1, 0, 3'b100);
        step();
        chk("sweep_frame_done", frame_done, 1);
        chk("xdone_suppress_plot", vga_plot, 0);
        chk("xdone_count_held", pixel_count, 19200);
        step();
        chk("frame_done_sticky", frame_done, 1);

        // Restart with plot high on the same edge
        drive(1, 1, 1, 1, 1, 0, 3'b100);
        step();
        chk("restart_frame_done", frame_done, 0);
        chk("restart_count", pixel_count, 0);

        // Saturation of pixel_count
        drive(0, 0, 0, 0, 1, 0, 3'b011);
        for (int i = 0; i < 32770; i++) step();
        chk("sat_count", pixel_count, 32767);
        chk("sat_plot", vga_plot, 1);

        // Asynchronous reset mid-sweep at (80,60)
        drive(1, 1, 1, 1, 0, 1, 3'b000);
        step();
        drive(0, 0, 1, 0, 0, 1, 3'b000);
        for (int i = 0; i < 80; i++) step();
        drive(0, 0, 0, 1, 0, 1, 3'b000);
        for (int i = 0; i < 60; i++) step();
        drive(0, 0, 0, 0, 1, 1, 3'b000);
        step();
        chk("mid_vga_x", vga_x, 80);
        chk("mid_vga_y", vga_y, 60);
        chk("mid_vga_colour", vga_colour, 3'b100);
        chk("mid_plot", vga_plot, 1);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_vga_x", vga_x, 0);
        chk("arst_vga_y", vga_y, 0);
        chk("arst_vga_colour", vga_colour, 0);
        chk("arst_vga_plot", vga_plot, 0);
        chk("arst_count", pixel_count, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_xdone", xdone, 0);
        chk("arst_ydone", ydone, 0);
        step();
        chk("arst_hold_plot", vga_plot, 0);
        @(negedge clock);
        resetb = 1'b1;
        drive(1, 1, 1, 1, 0, 0, 3'b101);
        step();
        chk("post_rst_count", pixel_count, 0);
        drive(0, 0, 0, 0, 1, 0, 3'b101);
        step();
        chk("post_rst_vga_x", vga_x, 0);
        chk("post_rst_vga_y", vga_y, 0);
        chk("post_rst_colour", vga_colour, 3'b101);
        chk("post_rst_plot", vga_plot, 1);
        chk("post_rst_count1", pixel_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
